// File: rtl/nf_fetch_unit_pkg.sv
// Shared types and constants for the nanoFOX instruction fetch stage.
package nf_fetch_unit_pkg;

   typedef enum logic [1:0] {
      IF_RST,
      IF_REQ,
      IF_WAIT,
      IF_DROP
   } nf_if_state_t;

   localparam logic [31:0] NF_INSTR_STEP = 32'd4;

endpackage

// File: rtl/nf_fetch_skid.sv
// One-entry instruction/PC holding buffer for the fetch stage.
module nf_fetch_skid (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_load,
   input  logic        i_unload,
   input  logic        i_flush,
   input  logic [31:0] i_instr,
   input  logic [31:0] i_pc,
   output logic [31:0] o_instr,
   output logic [31:0] o_pc,
   output logic        o_vld
);

   logic [31:0] r_instr;
   logic [31:0] r_pc;
   logic        r_vld;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_instr <= '0;
         r_pc    <= '0;
         r_vld   <= 1'b0;
      end else if (i_flush) begin
         r_vld <= 1'b0;
      end else if (i_load) begin
         r_instr <= i_instr;
         r_pc    <= i_pc;
         r_vld   <= 1'b1;
      end else if (i_unload) begin
         r_vld <= 1'b0;
      end
   end

   assign o_instr = r_instr;
   assign o_pc    = r_pc;
   assign o_vld   = r_vld;

endmodule

// File: rtl/nf_fetch_unit.sv
// nanoFOX fetch stage: single-outstanding imem requests, skid buffer, branch flush.
// Optional NF_FETCH_ALIGN_CHECK_EN: force-align branch targets and flag misalignment.
module nf_fetch_unit
   import nf_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pc_b_en,
   input  logic [31:0] pc_branch,
   input  logic        stall_if,
   output logic [31:0] instr_addr,
   output logic        instr_req,
   input  logic        instr_ack,
   input  logic [31:0] instr_rd,
   output logic [31:0] instr_if,
   output logic [31:0] pc_if,
   output logic        instr_vld,
   output logic        misalign_err
);

   nf_if_state_t r_state, w_state_nxt;
   logic [31:0]  r_fetch_pc, w_fetch_nxt;
   logic [31:0]  r_redirect_pc, w_redir_nxt;
   logic [31:0]  r_instr_if, r_pc_if;
   logic         r_instr_vld;
   logic [31:0]  w_target;
   logic         w_out_ready;
   logic         w_req, w_out_mem, w_out_skid, w_skid_load, w_skid_unload;
   logic [31:0]  w_skid_instr, w_skid_pc;
   logic         w_skid_vld;

`ifdef NF_FETCH_ALIGN_CHECK_EN
   logic r_misalign;

   assign w_target = {pc_branch[31:2], 2'b00};

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_misalign <= 1'b0;
      else if (pc_b_en && (pc_branch[1:0] != 2'b00))
         r_misalign <= 1'b1;
   end

   assign misalign_err = r_misalign;
`else
   assign w_target     = pc_branch;
   assign misalign_err = 1'b0;
`endif

   assign w_out_ready = !stall_if || !r_instr_vld;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IF_RST;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_fetch_nxt   = r_fetch_pc;
      w_redir_nxt   = r_redirect_pc;
      w_req         = 1'b0;
      w_out_mem     = 1'b0;
      w_out_skid    = 1'b0;
      w_skid_load   = 1'b0;
      w_skid_unload = 1'b0;
      case (r_state)
         IF_RST: begin
            w_state_nxt = IF_REQ;
            if (pc_b_en) w_fetch_nxt = w_target;
         end
         IF_REQ: begin
            w_req = 1'b1;
            if (pc_b_en) begin
               // Without an ack the bus request must complete, so park it in DROP.
               if (instr_ack) begin
                  w_fetch_nxt = w_target;
               end else begin
                  w_redir_nxt = w_target;
                  w_state_nxt = IF_DROP;
               end
            end else if (instr_ack) begin
               w_fetch_nxt = r_fetch_pc + NF_INSTR_STEP;
               if (w_out_ready) begin
                  w_out_mem = 1'b1;
               end else begin
                  w_skid_load = 1'b1;
                  w_state_nxt = IF_WAIT;
               end
            end
         end
         IF_WAIT: begin
            if (pc_b_en) begin
               w_fetch_nxt = w_target;
               w_state_nxt = IF_REQ;
            end else if (w_out_ready) begin
               w_out_skid    = 1'b1;
               w_skid_unload = 1'b1;
               w_state_nxt   = IF_REQ;
            end
         end
         IF_DROP: begin
            w_req = 1'b1;
            if (pc_b_en) begin
               w_redir_nxt = w_target;
               if (instr_ack) begin
                  w_fetch_nxt = w_target;
                  w_state_nxt = IF_REQ;
               end
            end else if (instr_ack) begin
               w_fetch_nxt = r_redirect_pc;
               w_state_nxt = IF_REQ;
            end
         end
         default: w_state_nxt = IF_RST;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_pc    <= RESET_PC;
         r_redirect_pc <= '0;
         r_instr_if    <= '0;
         r_pc_if       <= '0;
         r_instr_vld   <= 1'b0;
      end else begin
         r_fetch_pc    <= w_fetch_nxt;
         r_redirect_pc <= w_redir_nxt;
         if (pc_b_en) begin
            r_instr_vld <= 1'b0;
         end else if (w_out_mem) begin
            r_instr_if  <= instr_rd;
            r_pc_if     <= r_fetch_pc;
            r_instr_vld <= 1'b1;
         end else if (w_out_skid) begin
            r_instr_if  <= w_skid_instr;
            r_pc_if     <= w_skid_pc;
            r_instr_vld <= w_skid_vld;
         end else if (w_out_ready) begin
            r_instr_vld <= 1'b0;
         end
      end
   end

   nf_fetch_skid u_skid (
      .clk      (clk),
      .rst      (rst),
      .i_load   (w_skid_load),
      .i_unload (w_skid_unload),
      .i_flush  (pc_b_en),
      .i_instr  (instr_rd),
      .i_pc     (r_fetch_pc),
      .o_instr  (w_skid_instr),
      .o_pc     (w_skid_pc),
      .o_vld    (w_skid_vld)
   );

   assign instr_addr = r_fetch_pc;
   assign instr_req  = w_req;
   assign instr_if   = r_instr_if;
   assign pc_if      = r_pc_if;
   assign instr_vld  = r_instr_vld;

endmodule
